// File: rtl/adc_seq_pkg.sv
// Shared types for the SAR ADC sequencer.
// State encoding and enable-mask bit positions.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SAMP,
        COMP,
        UPDATE,
        DONE
    } state_t;

    localparam int EN_INIT     = 5;
    localparam int EN_SAMP_P   = 4;
    localparam int EN_SAMP_N   = 3;
    localparam int EN_COMP     = 2;
    localparam int EN_UPDATE_P = 1;
    localparam int EN_UPDATE_N = 0;

endpackage

// File: rtl/adc_sequencer_rr_pick.sv
// Finds the lowest enabled channel at or above a base index.
// Purely combinational; base is one bit wider so base==Nchan means none.
module rr_pick #(
    parameter int Nchan = 4,
    parameter int CW    = 2
) (
    input  logic [Nchan-1:0] chan_mask,
    input  logic [CW:0]      pointer,
    output logic [Nchan-1:0] sel,
    output logic [CW-1:0]    idx,
    output logic             found
);

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        // Descending walk so the lowest qualifying index wins.
        for (int i = Nchan - 1; i >= 0; i--) begin
            if (chan_mask[i] && (i >= int'(pointer))) begin
                sel    = '0;
                sel[i] = 1'b1;
                idx    = CW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// SAR ADC control path: phase timing, channel scan, bit capture
// and valid/ready result delivery with a sticky overrun flag.
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int Madc  = 17,
    parameter int Nchan = 4,
    parameter int Wsamp = 4,
    parameter int CW    = (Nchan > 1) ? $clog2(Nchan) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [Nchan-1:0]          chan_mask,
    input  logic [Wsamp-1:0]          samp_cycles,
    input  logic [$clog2(Madc+1)-1:0] ncomp,
    input  logic [5:0]                en_mask,
    input  logic                      comp_out,
    output logic                      seq_init,
    output logic                      seq_samp,
    output logic                      seq_comp,
    output logic                      seq_update,
    output logic                      en_init,
    output logic                      en_samp_p,
    output logic                      en_samp_n,
    output logic                      en_comp,
    output logic                      en_update_p,
    output logic                      en_update_n,
    output logic [Nchan-1:0]          chan_sel,
    output logic                      busy,
    output logic [Madc-1:0]           res_data,
    output logic [CW-1:0]             res_chan,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int NW = $clog2(Madc + 1);
    localparam logic [Madc-1:0] MSB_BIT = Madc'(1) << (Madc - 1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    ptr;
    logic [Wsamp-1:0] samp_len;
    logic [Wsamp-1:0] samp_cnt;
    logic [NW-1:0]    comp_len;
    logic [NW-1:0]    comp_cnt;
    logic [5:0]       en_lat;
    logic [Madc-1:0]  sar;
    logic [Madc-1:0]  bit_ptr;

    logic [CW:0]      first_base;
    logic [CW:0]      next_base;
    logic [Nchan-1:0] first_sel;
    logic [Nchan-1:0] next_sel;
    logic [CW-1:0]    first_idx;
    logic [CW-1:0]    next_idx;
    logic             first_found;
    logic             next_found;
    logic             use_next;
    logic             enter_init;
    logic             drop;

    assign first_base = (state == DONE) ? '0 : (CW+1)'(ptr);
    assign next_base  = (CW+1)'(ptr) + (CW+1)'(1);

    rr_pick #(.Nchan(Nchan), .CW(CW)) u_pick_first (
        .chan_mask (chan_mask),
        .pointer   (first_base),
        .sel       (first_sel),
        .idx       (first_idx),
        .found     (first_found)
    );

    rr_pick #(.Nchan(Nchan), .CW(CW)) u_pick_next (
        .chan_mask (chan_mask),
        .pointer   (next_base),
        .sel       (next_sel),
        .idx       (next_idx),
        .found     (next_found)
    );

    assign use_next   = (state == DONE) && next_found;
    assign enter_init = (state_n == INIT);
    assign drop       = (state == DONE) && res_valid && !res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            seq_init   <= 1'b0;
            seq_samp   <= 1'b0;
            seq_comp   <= 1'b0;
            seq_update <= 1'b0;
        end else begin
            state      <= state_n;
            seq_init   <= (state_n == INIT);
            seq_samp   <= (state_n == SAMP);
            seq_comp   <= (state_n == COMP);
            seq_update <= (state_n == UPDATE);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start && first_found) state_n = INIT;
            INIT:    state_n = SAMP;
            SAMP:    if (samp_cnt == samp_len) state_n = COMP;
            COMP:    state_n = UPDATE;
            UPDATE:  state_n = (comp_cnt == comp_len) ? DONE : COMP;
            DONE: begin
                if (next_found || (continuous && first_found))
                    state_n = INIT;
                else
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        en_init     = busy & en_lat[EN_INIT];
        en_samp_p   = busy & en_lat[EN_SAMP_P];
        en_samp_n   = busy & en_lat[EN_SAMP_N];
        en_comp     = busy & en_lat[EN_COMP];
        en_update_p = busy & en_lat[EN_UPDATE_P];
        en_update_n = busy & en_lat[EN_UPDATE_N];
    end

    // Conversion setup is frozen at INIT entry; SAR bits fill MSB-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            chan_sel <= '0;
            samp_len <= '0;
            samp_cnt <= '0;
            comp_len <= '0;
            comp_cnt <= '0;
            en_lat   <= '0;
            sar      <= '0;
            bit_ptr  <= '0;
        end else begin
            if (enter_init) begin
                ptr      <= use_next ? next_idx : first_idx;
                chan_sel <= use_next ? next_sel : first_sel;
                samp_len <= (samp_cycles == '0) ? Wsamp'(1) : samp_cycles;
                comp_len <= (ncomp == '0 || ncomp > NW'(Madc)) ?
                            NW'(Madc) : ncomp;
                en_lat   <= en_mask;
                sar      <= '0;
                bit_ptr  <= MSB_BIT;
                samp_cnt <= Wsamp'(1);
                comp_cnt <= '0;
            end else if (state_n == IDLE) begin
                ptr      <= '0;
                chan_sel <= '0;
            end
            if (state == SAMP)
                samp_cnt <= samp_cnt + Wsamp'(1);
            if (state == COMP) begin
                if (comp_out)
                    sar <= sar | bit_ptr;
                bit_ptr  <= bit_ptr >> 1;
                comp_cnt <= comp_cnt + NW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_data  <= '0;
            res_chan  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == DONE) begin
                if (!res_valid || res_ready) begin
                    res_data  <= sar;
                    res_chan  <= ptr;
                    res_valid <= 1'b1;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (drop)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: timing, capture, scan,
// backpressure/overrun and asynchronous reset.
module tb_adc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [3:0]  chan_mask = '0;
    logic [3:0]  samp_cycles = '0;
    logic [4:0]  ncomp = '0;
    logic [5:0]  en_mask = '0;
    logic        comp_out = 1'b0;
    logic        seq_init, seq_samp, seq_comp, seq_update;
    logic        en_init, en_samp_p, en_samp_n;
    logic        en_comp, en_update_p, en_update_n;
    logic [3:0]  chan_sel;
    logic        busy;
    logic [16:0] res_data;
    logic [1:0]  res_chan;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int pat = 0;
    int dec_k = 0;
    int conv_n = 0;

    adc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .chan_mask   (chan_mask),
        .samp_cycles (samp_cycles),
        .ncomp       (ncomp),
        .en_mask     (en_mask),
        .comp_out    (comp_out),
        .seq_init    (seq_init),
        .seq_samp    (seq_samp),
        .seq_comp    (seq_comp),
        .seq_update  (seq_update),
        .en_init     (en_init),
        .en_samp_p   (en_samp_p),
        .en_samp_n   (en_samp_n),
        .en_comp     (en_comp),
        .en_update_p (en_update_p),
        .en_update_n (en_update_n),
        .chan_sel    (chan_sel),
        .busy        (busy),
        .res_data    (res_data),
        .res_chan    (res_chan),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Comparator model: 0 alternates 1,0,..; 1 all ones; 2 conversion parity.
    always @(negedge clk) begin
        if (seq_init) begin
            dec_k  = 0;
            conv_n = conv_n + 1;
        end
        if (pat == 0)
            comp_out = (dec_k % 2 == 0);
        else if (pat == 1)
            comp_out = 1'b1;
        else
            comp_out = conv_n[0];
        if (seq_comp)
            dec_k = dec_k + 1;
    end

    wire [5:0] en_vec = {en_init, en_samp_p, en_samp_n,
                         en_comp, en_update_p, en_update_n};
    wire [12:0] out_vec = {seq_init, seq_samp, seq_comp, seq_update,
                           en_vec, busy, res_valid, overrun};
    wire in_done = busy && !seq_init && !seq_samp &&
                   !seq_comp && !seq_update;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n, output int ns, output int nc);
        n  = 0;
        ns = 0;
        nc = 0;
        while (!res_valid && n < 400) begin
            if (seq_samp) ns++;
            if (seq_comp) nc++;
            tick();
            n++;
        end
        chk("valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic wait_done(input int par);
        int n = 0;
        while (!(in_done && (par < 0 || conv_n % 2 == par)) && n < 200) begin
            tick();
            n++;
        end
        chk("done_timeout", 32'(in_done), 32'd1);
    endtask

    int n, ns, nc, first_par;
    logic [16:0] first_data;

    initial begin
        #3;
        chk("rst_out", 32'(out_vec), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_sel", 32'(chan_sel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single full-resolution conversion
        pat = 0; chan_mask = 4'b0001; samp_cycles = 4'd4;
        ncomp = 5'd17; en_mask = 6'b101010;
        start_pulse();
        chk("t1_init", 32'(seq_init), 32'd1);
        chk("t1_sel", 32'(chan_sel), 32'b0001);
        chk("t1_en", 32'(en_vec), 32'b101010);
        en_mask = 6'b000000;
        tick();
        chk("t1_en_latched", 32'(en_vec), 32'b101010);
        wait_valid(n, ns, nc);
        chk("t1_latency", 32'(n + 2), 32'd41);
        chk("t1_samp", 32'(ns), 32'd4);
        chk("t1_comp", 32'(nc), 32'd17);
        chk("t1_data", 32'(res_data), 32'h15555);
        chk("t1_chan", 32'(res_chan), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_sel_idle", 32'(chan_sel), 32'd0);
        tick();
        chk("t1_hold", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        tick();
        chk("t1_accept", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Empty mask start is ignored
        chan_mask = 4'b0000;
        start_pulse();
        chk("t2_nomask", 32'(busy), 32'd0);

        // Reduced resolution, zero sampling time treated as one
        chan_mask = 4'b0001; pat = 1; samp_cycles = 4'd0; ncomp = 5'd10;
        start_pulse();
        wait_valid(n, ns, nc);
        chk("t2_latency", 32'(n + 1), 32'd24);
        chk("t2_data", 32'(res_data), 32'h1FF80);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ncomp = 5'd0;
        start_pulse();
        wait_valid(n, ns, nc);
        chk("t2_n0_comp", 32'(nc), 32'd17);
        chk("t2_n0_data", 32'(res_data), 32'h1FFFF);
        res_ready = 1'b1;
        tick();

        // Two-channel scan with the consumer always ready
        chan_mask = 4'b1010; samp_cycles = 4'd1; ncomp = 5'd2;
        start_pulse();
        chk("t3_sel1", 32'(chan_sel), 32'b0010);
        wait_valid(n, ns, nc);
        chk("t3_chan1", 32'(res_chan), 32'd1);
        chk("t3_data1", 32'(res_data), 32'h18000);
        chk("t3_sel3", 32'(chan_sel), 32'b1000);
        chk("t3_reinit", 32'(seq_init), 32'd1);
        tick();
        chk("t3_drop", 32'(res_valid), 32'd0);
        wait_valid(n, ns, nc);
        chk("t3_chan3", 32'(res_chan), 32'd3);
        chk("t3_idle", 32'(busy), 32'd0);
        tick();
        chk("t3_drop2", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Backpressure and overrun in continuous mode
        pat = 2; chan_mask = 4'b0001; continuous = 1'b1;
        start_pulse();
        wait_valid(n, ns, nc);
        first_par  = conv_n % 2;
        first_data = (first_par == 1) ? 17'h18000 : 17'h00000;
        chk("t4_first", 32'(res_data), 32'(first_data));
        repeat (10) tick();
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_kept", 32'(res_data), 32'(first_data));
        chk("t4_valid", 32'(res_valid), 32'd1);
        wait_done(-1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t4_set_wins", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t4_clear", 32'(overrun), 32'd0);

        // Accept and publish on the same edge
        wait_done(1 - first_par);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t5_valid", 32'(res_valid), 32'd1);
        chk("t5_no_ovr", 32'(overrun), 32'd0);
        chk("t5_new", 32'(res_data),
            (first_par == 1) ? 32'h00000 : 32'h18000);
        tick();
        chk("t5_hold", 32'(res_valid), 32'd1);
        continuous = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("t5_scan_end", 32'(busy), 32'd0);
        tick();
        chk("t5_drained", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Asynchronous reset during COMP with a result pending
        pat = 1;
        start_pulse();
        wait_valid(n, ns, nc);
        start_pulse();
        n = 0;
        while (!seq_comp && n < 50) begin
            tick();
            n++;
        end
        chk("t6_in_comp", 32'(seq_comp), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_out", 32'(out_vec), 32'd0);
        chk("t6_sel", 32'(chan_sel), 32'd0);
        chk("t6_data", 32'(res_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t6_idle", 32'(out_vec), 32'd0);
        pat = 0; samp_cycles = 4'd4; ncomp = 5'd17; en_mask = 6'b010101;
        start_pulse();
        chk("t6_en", 32'(en_vec), 32'b010101);
        wait_valid(n, ns, nc);
        chk("t6_latency", 32'(n + 1), 32'd41);
        chk("t6_result", 32'(res_data), 32'h15555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
